// File: rtl/vdp_host_port.sv
// vdp_host_port: host CPU interface for the VDP.
// Two-port protocol: a control port takes two-byte address/register writes and
// status reads, and a data port does VRAM reads and writes with address
// auto-increment. Reads are served from a read-ahead buffer that is refilled
// from VRAM by a small IDLE/FETCH/CAPTURE sequencer.
module vdp_host_port #(
    parameter int AW   = 14,
    parameter int NREG = 8
) (
    input  logic              pxclk,
    input  logic              reset_n,
    input  logic              wr_stb,
    input  logic              rd_stb,
    input  logic              mode,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata,
    output logic              rdata_valid,
    output logic              busy,
    input  logic [7:0]        status_in,
    output logic              status_ack,
    output logic [AW-1:0]     vram_addr,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic              vram_re,
    input  logic [7:0]        vram_rdata,
    output logic [8*NREG-1:0] regs
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      addr_ptr_q, addr_ptr_d;
    logic [7:0]         buffer_q, buffer_d;
    logic [7:0]         latch_q, latch_d;
    logic               flag_q, flag_d;
    logic [8*NREG-1:0]  regs_q, regs_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               status_ack_q, status_ack_d;
    logic [AW-1:0]      vram_addr_q, vram_addr_d;
    logic [7:0]         vram_wdata_q, vram_wdata_d;
    logic               vram_we_q, vram_we_d;
    logic               vram_re_q, vram_re_d;

    logic               fetch_en;
    logic [AW-1:0]      fetch_addr;
    logic [AW-1:0]      new_addr;

    // Decode host strobes in IDLE, sequence read-ahead fetches, and compute next state.
    always_comb begin
        state_d       = state_q;
        addr_ptr_d    = addr_ptr_q;
        buffer_d      = buffer_q;
        latch_d       = latch_q;
        flag_d        = flag_q;
        regs_d        = regs_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        status_ack_d  = 1'b0;
        vram_addr_d   = vram_addr_q;
        vram_wdata_d  = vram_wdata_q;
        vram_we_d     = 1'b0;
        vram_re_d     = 1'b0;
        fetch_en      = 1'b0;
        fetch_addr    = addr_ptr_q;
        new_addr      = {wdata[AW-9:0], latch_q};

        case (state_q)
            IDLE: begin
                if (wr_stb) begin
                    if (mode) begin
                        if (!flag_q) begin
                            latch_d = wdata;
                            flag_d  = 1'b1;
                        end else begin
                            flag_d = 1'b0;
                            if (wdata[7]) begin
                                for (int k = 0; k < NREG; k++) begin
                                    if (32'(wdata[2:0]) == k) begin
                                        regs_d[8*k +: 8] = latch_q;
                                    end
                                end
                            end else if (wdata[6]) begin
                                addr_ptr_d = new_addr;
                            end else begin
                                fetch_en   = 1'b1;
                                fetch_addr = new_addr;
                            end
                        end
                    end else begin
                        vram_we_d    = 1'b1;
                        vram_addr_d  = addr_ptr_q;
                        vram_wdata_d = wdata;
                        buffer_d     = wdata;
                        addr_ptr_d   = addr_ptr_q + AW'(1);
                        flag_d       = 1'b0;
                    end
                end else if (rd_stb) begin
                    flag_d        = 1'b0;
                    rdata_valid_d = 1'b1;
                    if (mode) begin
                        rdata_d      = status_in;
                        status_ack_d = 1'b1;
                    end else begin
                        rdata_d    = buffer_q;
                        fetch_en   = 1'b1;
                        fetch_addr = addr_ptr_q;
                    end
                end

                // The pointer advances past the fetched byte as soon as the fetch is launched.
                if (fetch_en) begin
                    state_d     = FETCH;
                    vram_re_d   = 1'b1;
                    vram_addr_d = fetch_addr;
                    addr_ptr_d  = fetch_addr + AW'(1);
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                state_d  = IDLE;
                buffer_d = vram_rdata;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register all state and outputs; reset clears everything and aborts a fetch.
    always_ff @(posedge pxclk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_ptr_q    <= '0;
            buffer_q      <= '0;
            latch_q       <= '0;
            flag_q        <= 1'b0;
            regs_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            status_ack_q  <= 1'b0;
            vram_addr_q   <= '0;
            vram_wdata_q  <= '0;
            vram_we_q     <= 1'b0;
            vram_re_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_ptr_q    <= addr_ptr_d;
            buffer_q      <= buffer_d;
            latch_q       <= latch_d;
            flag_q        <= flag_d;
            regs_q        <= regs_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            status_ack_q  <= status_ack_d;
            vram_addr_q   <= vram_addr_d;
            vram_wdata_q  <= vram_wdata_d;
            vram_we_q     <= vram_we_d;
            vram_re_q     <= vram_re_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign status_ack  = status_ack_q;
    assign vram_addr   = vram_addr_q;
    assign vram_wdata  = vram_wdata_q;
    assign vram_we     = vram_we_q;
    assign vram_re     = vram_re_q;
    assign regs        = regs_q;

endmodule

// File: tb/tb_vdp_host_port.sv
// tb_vdp_host_port: scoreboard bench for the VDP host port.
// Host operations update a small protocol model and push the VRAM/host events
// they should cause; a negedge monitor pops and compares each event as it appears.
module tb_vdp_host_port;

    logic        pxclk;
    logic        reset_n;
    logic        wr_stb;
    logic        rd_stb;
    logic        mode;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        busy;
    logic [7:0]  status_in;
    logic        status_ack;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        vram_re;
    logic [7:0]  vram_rdata;
    logic [63:0] regs;

    vdp_host_port #(.AW(14), .NREG(8)) dut (
        .pxclk       (pxclk),
        .reset_n     (reset_n),
        .wr_stb      (wr_stb),
        .rd_stb      (rd_stb),
        .mode        (mode),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .status_in   (status_in),
        .status_ack  (status_ack),
        .vram_addr   (vram_addr),
        .vram_wdata  (vram_wdata),
        .vram_we     (vram_we),
        .vram_re     (vram_re),
        .vram_rdata  (vram_rdata),
        .regs        (regs)
    );

    typedef enum logic [1:0] {EV_WE, EV_RE, EV_RD} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [13:0] addr;
        logic [7:0]  data;
        logic        ack;
    } ev_t;

    ev_t         expQ[$];
    int          testsRun;
    int          testsFailed;

    logic [7:0]  mem [0:16383];
    logic        mFlag;
    logic [7:0]  mLatch;
    logic [13:0] mPtr;
    logic [7:0]  mBuf;
    logic [63:0] mRegs;

    // Free-running pixel clock.
    initial begin
        pxclk = 1'b0;
        forever #5 pxclk = ~pxclk;
    end

    // Synchronous-read VRAM model: data appears the cycle after vram_re.
    always @(posedge pxclk) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        if (vram_re) vram_rdata <= mem[vram_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic popCompare(input ev_kind_t kind, input logic [13:0] addr,
                              input logic [7:0] data, input logic ack);
        ev_t e;
        if (expQ.size() == 0) begin
            checkOutput("sb_unexpected_event", {62'd0, kind}, 64'hFF);
        end else begin
            e = expQ.pop_front();
            checkOutput("sb_kind", {62'd0, kind}, {62'd0, e.kind});
            checkOutput("sb_addr", {50'd0, addr}, {50'd0, e.addr});
            checkOutput("sb_data", {56'd0, data}, {56'd0, e.data});
            checkOutput("sb_ack",  {63'd0, ack},  {63'd0, e.ack});
        end
    endtask

    // Monitor: compare every DUT-produced event against the scoreboard front.
    always @(negedge pxclk) begin
        if (vram_we && vram_re) checkOutput("we_re_overlap", 64'd1, 64'd0);
        if (vram_we)     popCompare(EV_WE, vram_addr, vram_wdata, 1'b0);
        if (rdata_valid) popCompare(EV_RD, 14'd0, rdata, status_ack);
        if (vram_re)     popCompare(EV_RE, vram_addr, 8'd0, 1'b0);
        if (status_ack && !rdata_valid) checkOutput("stray_status_ack", 64'd1, 64'd0);
    end

    task automatic pushEv(input ev_kind_t kind, input logic [13:0] addr,
                          input logic [7:0] data, input logic ack);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.ack  = ack;
        expQ.push_back(e);
    endtask

    // Drive one strobe cycle; returns on the negedge after the sampling edge.
    task automatic applyStimulus(input logic w, input logic r, input logic m, input logic [7:0] d);
        @(negedge pxclk);
        wr_stb = w;
        rd_stb = r;
        mode   = m;
        wdata  = d;
        @(negedge pxclk);
        wr_stb = 1'b0;
        rd_stb = 1'b0;
        mode   = 1'b0;
        wdata  = 8'h00;
    endtask

    task automatic modelReset();
        mFlag  = 1'b0;
        mLatch = 8'h00;
        mPtr   = 14'd0;
        mBuf   = 8'h00;
        mRegs  = 64'd0;
    endtask

    task automatic ctrlWrite(input logic [7:0] b);
        logic [13:0] newAddr;
        if (!mFlag) begin
            mLatch = b;
            mFlag  = 1'b1;
        end else begin
            mFlag   = 1'b0;
            newAddr = {b[5:0], mLatch};
            if (b[7]) begin
                mRegs[8*b[2:0] +: 8] = mLatch;
            end else if (b[6]) begin
                mPtr = newAddr;
            end else begin
                pushEv(EV_RE, newAddr, 8'h00, 1'b0);
                mBuf = mem[newAddr];
                mPtr = newAddr + 14'd1;
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b1, b);
    endtask

    task automatic dataWrite(input logic [7:0] b);
        pushEv(EV_WE, mPtr, b, 1'b0);
        mBuf  = b;
        mPtr  = mPtr + 14'd1;
        mFlag = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, b);
    endtask

    task automatic dataRead();
        pushEv(EV_RD, 14'd0, mBuf, 1'b0);
        pushEv(EV_RE, mPtr, 8'h00, 1'b0);
        mBuf  = mem[mPtr];
        mPtr  = mPtr + 14'd1;
        mFlag = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic statusRead();
        pushEv(EV_RD, 14'd0, status_in, 1'b1);
        mFlag = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 8) begin
            @(negedge pxclk);
            n++;
        end
        checkOutput("busy_timeout", {63'd0, busy}, 64'd0);
    endtask

    // Overall time bound so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0123] = 8'h11;
        mem[14'h0124] = 8'h22;
        vram_rdata = 8'h00;
        wr_stb     = 1'b0;
        rd_stb     = 1'b0;
        mode       = 1'b0;
        wdata      = 8'h00;
        status_in  = 8'hA5;
        reset_n    = 1'b0;
        modelReset();
        repeat (3) @(negedge pxclk);

        $display("[TB] reset state");
        checkOutput("rst_regs",        regs,                  64'd0);
        checkOutput("rst_rdata",       {56'd0, rdata},        64'd0);
        checkOutput("rst_rdata_valid", {63'd0, rdata_valid},  64'd0);
        checkOutput("rst_busy",        {63'd0, busy},         64'd0);
        checkOutput("rst_status_ack",  {63'd0, status_ack},   64'd0);
        checkOutput("rst_vram_addr",   {50'd0, vram_addr},    64'd0);
        checkOutput("rst_vram_wdata",  {56'd0, vram_wdata},   64'd0);
        checkOutput("rst_vram_we",     {63'd0, vram_we},      64'd0);
        checkOutput("rst_vram_re",     {63'd0, vram_re},      64'd0);
        reset_n = 1'b1;

        $display("[TB] register write");
        ctrlWrite(8'h55);
        ctrlWrite(8'h83);
        checkOutput("reg3_write", regs, 64'h0000_0000_5500_0000);
        checkOutput("reg_model",  regs, mRegs);
        ctrlWrite(8'h9A);
        ctrlWrite(8'hFF);
        checkOutput("reg7_write", regs, 64'h9A00_0000_5500_0000);

        $display("[TB] write setup and auto-increment");
        ctrlWrite(8'h00);
        ctrlWrite(8'h40);
        dataWrite(8'hAA);
        dataWrite(8'hBB);
        dataWrite(8'hCC);

        $display("[TB] read setup and read-ahead");
        ctrlWrite(8'h23);
        ctrlWrite(8'h01);
        checkOutput("busy_fetch",   {63'd0, busy}, 64'd1);
        @(negedge pxclk);
        checkOutput("busy_capture", {63'd0, busy}, 64'd1);
        @(negedge pxclk);
        checkOutput("busy_done",    {63'd0, busy}, 64'd0);
        dataRead();
        waitIdle();
        dataRead();
        waitIdle();

        $display("[TB] address wrap");
        ctrlWrite(8'hFF);
        ctrlWrite(8'h7F);
        dataWrite(8'h5C);
        dataWrite(8'h6D);

        $display("[TB] status read resets the byte phase");
        ctrlWrite(8'h12);
        statusRead();
        @(negedge pxclk);
        checkOutput("status_ack_pulse", {63'd0, status_ack}, 64'd0);
        ctrlWrite(8'h34);
        ctrlWrite(8'h40);
        dataWrite(8'h77);

        $display("[TB] strobes while busy and write/read collision");
        dataRead();
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        waitIdle();
        dataRead();
        waitIdle();
        pushEv(EV_WE, mPtr, 8'h5A, 1'b0);
        mBuf  = 8'h5A;
        mPtr  = mPtr + 14'd1;
        mFlag = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h5A);
        dataRead();
        waitIdle();

        $display("[TB] reset during a fetch");
        dataRead();
        @(negedge pxclk);
        checkOutput("mid_fetch_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        @(negedge pxclk);
        modelReset();
        checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("mid_rst_regs", regs, 64'd0);
        reset_n = 1'b1;
        dataRead();
        waitIdle();

        repeat (3) @(negedge pxclk);
        checkOutput("sb_leftover", expQ.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vdp_host_port.md
Name: vdp_host_port

Overview:
- Host-side CPU interface for the VDP, directly upstream of the name/pattern/color VRAM and the VDP mode registers.
- Implements the TMS9918-style two-port protocol:
  - a control port for the two-byte address or register write, and status read;
  - a data port for VRAM read/write with address auto-increment and a read-ahead buffer.
- Drives the write/read side of the VRAM (1-cycle synchronous-read memory) and presents the register file to the display pipeline.

Parameters:
- AW, 14, VRAM address width; legal 9..14.
- NREG, 8, number of 8-bit mode registers; index taken from second control byte [2:0].

Ports:
- pxclk  in  1  Single clock, shared with the display pipeline.
- reset_n  in  1  Synchronous, active-low reset.
- wr_stb  in  1  One-cycle host write strobe.
- rd_stb  in  1  One-cycle host read strobe.
- mode  in  1  Port select: 0 = data port, 1 = control port.
- wdata  in  8  Host write byte, sampled with wr_stb.
- rdata  out  8  Host read byte, valid when rdata_valid=1.
- rdata_valid  out  1  One-cycle pulse answering rd_stb.
- busy  out  1  Read-ahead fetch in progress; host must not strobe.
- status_in  in  8  Status byte from the display pipeline.
- status_ack  out  1  One-cycle pulse when status is read; upstream clears its flags.
- vram_addr  out  AW  VRAM address, registered.
- vram_wdata  out  8  VRAM write data, registered.
- vram_we  out  1  VRAM write enable, one-cycle pulse.
- vram_re  out  1  VRAM read request, one-cycle pulse.
- vram_rdata  in  8  VRAM read data, valid the cycle after vram_re.
- regs  out  8*NREG  Mode registers; reg k occupies bits [8k+7:8k].

Behaviour:
- Reset (reset_n=0 at posedge):
  - All outputs 0: regs, rdata, rdata_valid, busy, status_ack, vram_*.
  - Internal state cleared: addr_ptr=0, buffer=0, first-byte latch=0, phase flag=0, FSM=IDLE.
  - Reset during a fetch aborts it; the buffer is not updated.
- FSM states: IDLE, FETCH (vram_re high), CAPTURE (waiting on memory).
  - IDLE -> FETCH on a read-ahead trigger.
  - FETCH -> CAPTURE unconditionally.
  - CAPTURE -> IDLE; at the edge leaving CAPTURE, buffer <= vram_rdata.
  - busy=1 in FETCH and CAPTURE.
- Strobes are acted on only in IDLE. Strobes while busy are ignored with no state change.
- If wr_stb and rd_stb coincide, the write wins and rd_stb is ignored.
- All reactions are registered; effects appear the cycle after the strobe edge.
- Control write, phase flag = 0:
  - latch <= wdata; flag <= 1.
- Control write, phase flag = 1 (flag <= 0 afterwards):
  - wdata[7]=1 (register write): regs[wdata[2:0]] <= latch. Index >= NREG is ignored. wdata[6:3] are don't-care.
  - wdata[7]=0 (address set): addr_ptr <= {wdata[AW-9:0], latch}.
  - If wdata[7]=0 and wdata[6]=0, it is a read setup: trigger a read-ahead from the new address.
  - If wdata[6]=1, it is a write setup: no fetch.
- Data write:
  - vram_we=1, vram_addr=addr_ptr, vram_wdata=wdata for one cycle.
  - buffer <= wdata; addr_ptr <= addr_ptr+1; flag <= 0.
- Data read:
  - rdata <= buffer, rdata_valid pulses; flag <= 0.
  - Read-ahead is triggered in the same edge.
- Read-ahead:
  - On entering FETCH: vram_addr=addr_ptr, vram_re=1; addr_ptr <= addr_ptr+1.
  - Buffer is updated 2 cycles after the trigger edge.
- Status read:
  - rdata <= status_in, rdata_valid=1, status_ack=1 (one cycle); flag <= 0. addr_ptr is unchanged.
- Control-port read of the data buffer does not exist.
- addr_ptr wraps from 2^AW-1 to 0 with no flag.
- vram_we and vram_re are never high in the same cycle.

Test Plan:
1. Register write: ctrl 0x55 then ctrl 0x83 -> regs[31:24]=0x55 the cycle after the second strobe; other regs stay 0; no vram_we or vram_re pulse.
2. Write setup plus auto-increment: ctrl 0x00, ctrl 0x40, then data 0xAA, 0xBB.
   - vram_we pulses at addr 0x0000 (0xAA) and 0x0001 (0xBB).
   - addr_ptr ends at 0x0002.
3. Read setup plus read-ahead: preload VRAM[0x0123]=0x11 and [0x0124]=0x22; ctrl 0x23, ctrl 0x01.
   - vram_re fires at 0x0123; busy=1 for 2 cycles.
   - Data read -> rdata=0x11 with rdata_valid; the next fetch is at 0x0124; the next read returns 0x22.
4. Wrap plus phase reset:
   - ctrl 0xFF, ctrl 0x7F, data write -> vram_addr=0x3FFF; the next write goes to 0x0000.
   - Separately: ctrl 0x12, then status read -> status_ack=1, rdata=status_in. The next ctrl byte is treated as a first byte.
5. Busy/collision:
   - rd_stb during busy -> no rdata_valid and no addr change.
   - wr_stb and rd_stb in the same IDLE cycle -> only the write is performed.
6. Reset mid-fetch: assert reset_n=0 during the CAPTURE cycle.
   - Next cycle: busy=0, regs=0, buffer=0.
   - A subsequent data read returns 0x00.
